serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//  Bit-serial add/subtract unit: the multi-cycle counterpart of the 4-bit ripple-carry adder.
//  Re-uses a single full-adder cell, one bit per clock, LSB first, under a start/done handshake.
//  Provides add and subtract (a - b - cin) for datapaths where area matters more than latency.
//  The existing adder bench style (random vectors, golden model, pass/fail file) verifies it.
// PARAMETERS
//  N        4    operand width in bits; N >= 1
// PORTS
//  clk     in   1    system clock, rising edge
//  reset   in   1    synchronous reset, active-high
//  start   in   1    request; accepted only when busy==0
//  op      in   1    0 = add (a+b+cin), 1 = subtract (a-b-cin)
//  a       in   N    operand A, sampled on the accepting edge
//  b       in   N    operand B, sampled on the accepting edge
//  cin     in   1    carry-in (add) / borrow-in (sub), sampled on the accepting edge
//  busy    out  1    high while bits are being processed
//  done    out  1    one-cycle pulse when result becomes valid
//  result  out  N+1  [N-1:0] sum/difference mod 2^N; [N] carry-out (add) / borrow-out (sub)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, result=0; shift regs, carry and bit counter cleared.
//  Reset has priority over every event, including mid-operation (abort, no done pulse).
//  States: IDLE -> SHIFT on start; SHIFT -> DONE after N bit cycles; DONE -> IDLE,
//   or DONE -> SHIFT if start is asserted during DONE (back-to-back operation).
//  Accept (state IDLE or DONE, start==1): latch A=a, B = op ? ~b : b, carry = cin ^ op,
//   latched op; clear bit counter; busy=1 from the next cycle.
//  SHIFT, each cycle: full adder on (A[0], B[0], carry); sum bit shifts into the result MSB
//   side (right-shift accumulator); A and B shift right; carry <= cout; counter++.
//  After the N-th SHIFT cycle: result[N] = final cout ^ op; result[N-1:0] = accumulated bits.
//  Latency: start sampled at edge k -> done=1 and result valid in cycle k+N+1.
//  done high for exactly one cycle (state DONE); busy=0 in IDLE and DONE.
//  result holds its value until the next accepted start; during SHIFT its value is undefined
//   for consumers (internal accumulator only updates the output register in DONE).
//  start while busy==1 is ignored; op/a/b/cin changes during SHIFT have no effect.
//  Arithmetic: add -> {cout,sum} == a+b+cin (N+1 bits); sub -> result[N-1:0] == (a-b-cin)
//   mod 2^N and result[N]==1 iff a < b+cin (unsigned borrow).
//  Bit counter width $clog2(N+1); terminal compare at N-1; no wrap beyond N.
// STRUCTURE
//  Package addsub_pkg: state enum {IDLE, SHIFT, DONE}; OP_ADD=1'b0, OP_SUB=1'b1.
//  Sub-module: fulladder (a, b, cin, sum, cout), the existing 1-bit cell, one instance.
//  Top holds the FSM, operand shift registers, carry flop, counter and output register.
// TESTING  (N=4, 20 ns clk; golden model = behavioural a+b+cin / a-b-cin)
//  add a=9 b=8 cin=1 -> result=5'h12, done pulse 5 cycles after start, busy high 4 cycles.
//  sub a=3 b=5 cin=0 -> result=5'h1E (diff 4'hE, borrow=1); sub a=7 b=2 cin=1 -> 5'h04.
//  start re-asserted with new operands while busy -> ignored; first result unchanged.
//  reset asserted at 2nd SHIFT cycle -> next cycle busy=0, done=0, result=0, no done pulse.
//  start held high in DONE cycle with add a=F b=F cin=1 -> back-to-back, result=5'h1F.
//  150 random {op,a,b,cin} ops -> log "a b || result | expected | match" to file, all match=1.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types for the bit-serial add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fulladder.sv
// 1-bit full-adder cell reused once per clock by the serial datapath.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full-adder cell, LSB first, N cycles per operation,
// start/done handshake with back-to-back restart from DONE.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N:0]   result
);

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [N:0]       result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             op_q, op_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [N:0]       acc_ext;

  fulladder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Sum bit enters at the MSB; taking [N:1] is the right shift and also works for N=1.
  assign acc_ext = {fa_sum, acc_q};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    op_d     = op_q;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      SHIFT: begin
        busy    = 1'b1;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = acc_ext[N:1];
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          result_d = {fa_cout ^ op_q, acc_ext[N:1]};
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Subtraction runs as a + ~b + ~cin, so the final carry is inverted into a borrow.
    if (state_q != SHIFT && start) begin
      state_d = SHIFT;
      a_d     = a;
      b_d     = (op == OP_SUB) ? ~b : b;
      carry_d = cin ^ op;
      op_d    = op;
      cnt_d   = '0;
      acc_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= OP_ADD;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (N=4): directed table, corner sequences, random ops.
module tb_serial_addsub;

  localparam int N = 4;

  typedef struct {
    logic       op;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [4:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [4:0] result;

  int checks = 0;
  int failures = 0;

  serial_addsub #(.N(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #10 clk = ~clk;

  function automatic logic [4:0] model(input logic m_op, input int ma, input int mb, input int mc);
    int r;
    if (!m_op) begin
      r = ma + mb + mc;
      return 5'(r);
    end
    r = ma - mb - mc;
    return {logic'(ma < mb + mc), 4'(r & 15)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a request on a negedge; returns at the negedge just after the accepting edge.
  task automatic issue(input logic t_op, input logic [3:0] ta, input logic [3:0] tb_, input logic tc);
    op = t_op; a = ta; b = tb_; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done, counting busy cycles on the way.
  task automatic wait_done(output logic got, output int busy_cnt);
    got = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) busy_cnt++;
        @(negedge clk);
      end
    end
  endtask

  task automatic run_op(input string name, input logic t_op, input logic [3:0] ta,
                        input logic [3:0] tb_, input logic tc, input logic [4:0] exp);
    logic got;
    int   bc;
    issue(t_op, ta, tb_, tc);
    wait_done(got, bc);
    check({name, "_done_seen"}, got, 1'b1);
    check({name, "_result"}, result, exp);
    if (got) begin
      check({name, "_busy_cycles"}, bc, N);
      check({name, "_busy_in_done"}, busy, 1'b0);
      @(negedge clk);
      check({name, "_done_one_cycle"}, done, 1'b0);
      check({name, "_result_held"}, result, exp);
    end
  endtask

  initial begin
    vec_t vecs[6];
    logic got;
    int   bc;
    logic [4:0] first_exp;
    logic       saw_done;

    vecs[0] = '{op: 1'b0, a: 4'h9, b: 4'h8, cin: 1'b1, exp: 5'h12};
    vecs[1] = '{op: 1'b1, a: 4'h3, b: 4'h5, cin: 1'b0, exp: 5'h1E};
    vecs[2] = '{op: 1'b1, a: 4'h7, b: 4'h2, cin: 1'b1, exp: 5'h04};
    vecs[3] = '{op: 1'b0, a: 4'h0, b: 4'h0, cin: 1'b0, exp: 5'h00};
    vecs[4] = '{op: 1'b1, a: 4'h5, b: 4'h4, cin: 1'b1, exp: 5'h00};
    vecs[5] = '{op: 1'b1, a: 4'h0, b: 4'hF, cin: 1'b1, exp: 5'h10};

    repeat (2) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", result, 5'h00);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      check($sformatf("table%0d_model", i), model(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin), vecs[i].exp);
      run_op($sformatf("table%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp);
    end

    // start re-asserted mid-operation with different operands must be ignored
    first_exp = model(1'b0, 6, 3, 0);
    issue(1'b0, 4'h6, 4'h3, 1'b0);
    @(negedge clk);
    op = 1'b1; a = 4'hF; b = 4'h1; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(got, bc);
    check("ignore_done_seen", got, 1'b1);
    check("ignore_result", result, first_exp);
    @(negedge clk);
    check("ignore_no_second_op", busy, 1'b0);

    // reset at the 2nd SHIFT cycle aborts with no done pulse
    issue(1'b0, 4'h3, 4'h4, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", result, 5'h00);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 1'b0);

    // back-to-back: start held during DONE
    issue(1'b1, 4'h2, 4'h9, 1'b0);
    wait_done(got, bc);
    check("b2b_first_done", got, 1'b1);
    check("b2b_first_result", result, model(1'b1, 2, 9, 0));
    issue(1'b0, 4'hF, 4'hF, 1'b1);
    check("b2b_busy_after_done", busy, 1'b1);
    wait_done(got, bc);
    check("b2b_second_done", got, 1'b1);
    check("b2b_second_busy", bc, N);
    check("b2b_second_result", result, 5'h1F);
    @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      logic       r_op;
      logic [3:0] ra, rb;
      logic       rc;
      r_op = 1'($urandom_range(0, 1));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      issue(r_op, ra, rb, rc);
      wait_done(got, bc);
      check($sformatf("rand%0d_done", i), got, 1'b1);
      check($sformatf("rand%0d_op%0d_%0h_%0h_%0h", i, r_op, ra, rb, rc), result, model(r_op, ra, rb, rc));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
